// File: rtl/decode_pkg.sv
// Shared opcode constants, decode enums and the decoded-beat record used by the decode stage.
// Wide fields (pc, imm) are sized for RV64; RV32 instances use the low half.
package decode_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_e;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic                funct7_b5;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] imm;
        logic                rd_we;
        mem_size_e           mem_size;
        logic                mem_unsigned;
        logic                illegal;
    } decoded_t;

    // Sign-extends to the full 64 bits; narrower datapaths take the low XLEN bits.
    function automatic logic [XLEN_MAX-1:0] build_imm(input imm_fmt_e fmt, input logic [31:7] bits);
        logic [XLEN_MAX-1:0] imm;
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{52{bits[31]}}, bits[31:20]};
            FMT_S:   imm = {{52{bits[31]}}, bits[31:25], bits[11:7]};
            FMT_B:   imm = {{51{bits[31]}}, bits[31], bits[7], bits[30:25], bits[11:8], 1'b0};
            FMT_U:   imm = {{32{bits[31]}}, bits[31:12], 12'b0};
            FMT_J:   imm = {{43{bits[31]}}, bits[31], bits[19:12], bits[20], bits[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I/RV64I decoder: raw instruction word to a decoded_t record.
// Illegal encodings keep only opcode and pc, with every other field cleared.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output decoded_t        dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    imm_fmt_e   fmt;
    logic       legal;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
    logic       use_f3;
    logic       f7b5;
    mem_size_e  size;
    logic       uns;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        fmt     = FMT_R;
        legal   = (instr[1:0] == 2'b11);
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        use_f3  = 1'b0;
        f7b5    = 1'b0;
        size    = MEM_B;
        uns     = 1'b0;

        case (opcode)
            OP_LUI, OP_AUIPC: begin
                fmt    = FMT_U;
                use_rd = 1'b1;
            end
            OP_JAL: begin
                fmt    = FMT_J;
                use_rd = 1'b1;
            end
            OP_JALR: begin
                fmt     = FMT_I;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                use_f3  = 1'b1;
                if (funct3 != 3'b000) legal = 1'b0;
            end
            OP_BRANCH: begin
                fmt     = FMT_B;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_f3  = 1'b1;
                if (funct3[2:1] == 2'b01) legal = 1'b0;
            end
            OP_LOAD: begin
                fmt     = FMT_I;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                use_f3  = 1'b1;
                case (funct3)
                    3'b000: size = MEM_B;
                    3'b001: size = MEM_H;
                    3'b010: size = MEM_W;
                    3'b011: begin
                        size = MEM_D;
                        if (XLEN == 32) legal = 1'b0;
                    end
                    3'b100: begin size = MEM_B; uns = 1'b1; end
                    3'b101: begin size = MEM_H; uns = 1'b1; end
                    3'b110: begin
                        size = MEM_W;
                        uns  = 1'b1;
                        if (XLEN == 32) legal = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                fmt     = FMT_S;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_f3  = 1'b1;
                size    = mem_size_e'(funct3[1:0]);
                if (funct3[2]) legal = 1'b0;
                if (XLEN == 32 && funct3 == 3'b011) legal = 1'b0;
            end
            OP_IMM: begin
                fmt     = FMT_I;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                use_f3  = 1'b1;
                // Only the shifts carry an arithmetic/logical selector in bit 30.
                if (funct3[1:0] == 2'b01) f7b5 = instr[30];
            end
            OP_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                use_f3  = 1'b1;
                f7b5    = instr[30];
            end
            OP_FENCE: begin
                fmt = FMT_R;
            end
            OP_SYSTEM: begin
                fmt = FMT_I;
                if (instr != INSTR_ECALL && instr != INSTR_EBREAK) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase

        dec        = '0;
        dec.pc     = XLEN_MAX'(pc);
        dec.opcode = opcode;
        if (!legal) begin
            dec.illegal = 1'b1;
        end else begin
            dec.funct3       = use_f3 ? funct3 : 3'd0;
            dec.funct7_b5    = f7b5;
            dec.rs1          = use_rs1 ? instr[19:15] : 5'd0;
            dec.rs2          = use_rs2 ? instr[24:20] : 5'd0;
            dec.rd           = use_rd ? instr[11:7] : 5'd0;
            dec.imm          = build_imm(fmt, instr[31:7]);
            dec.rd_we        = use_rd && (instr[11:7] != 5'd0);
            dec.mem_size     = size;
            dec.mem_unsigned = uns;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode pipeline stage between fetch and register read, with an optional
// two-entry skid buffer so in_ready never depends combinationally on out_ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7_b5,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rd_we,
    output logic [1:0]      out_mem_size,
    output logic            out_mem_unsigned,
    output logic            out_illegal
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

    state_e   state;
    state_e   state_nxt;
    decoded_t dec;
    decoded_t out_reg;
    decoded_t skid_reg;
    logic     accept;
    logic     drain;
    logic     load_out;
    logic     load_skid;
    logic     skid_to_out;

    decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (dec)
    );

    // Handshake: a beat moves on either side only in a cycle where valid and ready are both high.
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = !rst && (SKID_EN ? (state != ST_TWO) : (state == ST_EMPTY || out_ready));
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_nxt   = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        load_out  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        state_nxt = ST_TWO;
                        load_skid = 1'b1;
                    end else if (accept && drain) begin
                        load_out = 1'b1;
                    end else if (drain) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_nxt   = ST_ONE;
                        skid_to_out = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            state <= state_nxt;
            if (load_out) begin
                out_reg <= dec;
            end else if (skid_to_out) begin
                out_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= dec;
            end
        end
    end

    assign out_pc           = out_reg.pc[XLEN-1:0];
    assign out_opcode       = out_reg.opcode;
    assign out_funct3       = out_reg.funct3;
    assign out_funct7_b5    = out_reg.funct7_b5;
    assign out_rs1          = out_reg.rs1;
    assign out_rs2          = out_reg.rs2;
    assign out_rd           = out_reg.rd;
    assign out_imm          = out_reg.imm[XLEN-1:0];
    assign out_rd_we        = out_reg.rd_we;
    assign out_mem_size     = out_reg.mem_size;
    assign out_mem_unsigned = out_reg.mem_unsigned;
    assign out_illegal      = out_reg.illegal;

    // The stored records are 64 bits wide; on RV32 the top halves are never read.
    logic unused_wide_bits;
    assign unused_wide_bits = ^{out_reg.pc, out_reg.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV32 instance carries all handshake tests, an RV64
// instance sharing the same inputs checks XLEN-dependent immediates and legality.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, out_funct7_b5, out_rd_we, out_mem_unsigned, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [1:0]  out_mem_size;

    logic        o64_in_ready, o64_valid, o64_funct7_b5, o64_rd_we, o64_mem_unsigned, o64_illegal;
    logic [63:0] o64_pc, o64_imm;
    logic [6:0]  o64_opcode;
    logic [2:0]  o64_funct3;
    logic [4:0]  o64_rs1, o64_rs2, o64_rd;
    logic [1:0]  o64_mem_size;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7_b5(out_funct7_b5),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_rd_we(out_rd_we), .out_mem_size(out_mem_size),
        .out_mem_unsigned(out_mem_unsigned), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o64_in_ready),
        .in_instr(in_instr), .in_pc(64'(in_pc)), .flush(flush),
        .out_valid(o64_valid), .out_ready(out_ready), .out_pc(o64_pc),
        .out_opcode(o64_opcode), .out_funct3(o64_funct3), .out_funct7_b5(o64_funct7_b5),
        .out_rs1(o64_rs1), .out_rs2(o64_rs2), .out_rd(o64_rd), .out_imm(o64_imm),
        .out_rd_we(o64_rd_we), .out_mem_size(o64_mem_size),
        .out_mem_unsigned(o64_mem_unsigned), .out_illegal(o64_illegal)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat with the consumer ready; afterwards the beat sits on the outputs.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic check_dec(input string tag, input logic [31:0] pc, input logic [6:0] op,
                             input logic [2:0] f3, input logic f7, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                             input logic we, input logic [1:0] sz, input logic uns, input logic ill);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".pc"}, 64'(out_pc), 64'(pc));
        check({tag, ".opcode"}, 64'(out_opcode), 64'(op));
        check({tag, ".funct3"}, 64'(out_funct3), 64'(f3));
        check({tag, ".f7b5"}, 64'(out_funct7_b5), 64'(f7));
        check({tag, ".rs1"}, 64'(out_rs1), 64'(rs1));
        check({tag, ".rs2"}, 64'(out_rs2), 64'(rs2));
        check({tag, ".rd"}, 64'(out_rd), 64'(rd));
        check({tag, ".imm"}, 64'(out_imm), 64'(imm));
        check({tag, ".rd_we"}, 64'(out_rd_we), 64'(we));
        check({tag, ".size"}, 64'(out_mem_size), 64'(sz));
        check({tag, ".uns"}, 64'(out_mem_unsigned), 64'(uns));
        check({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    initial begin
        int idx;
        int popped;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();

        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd0);
        check("rst.rd", 64'(out_rd), 64'd0);
        check("rst.imm", 64'(out_imm), 64'd0);
        rst = 1'b0;
        #1;
        check("rst.in_ready_after", 64'(in_ready), 64'd1);

        // Directed decode vectors
        send(32'h0081_2283, 32'h0000_0100);
        check_dec("lw", 32'h100, 7'h03, 3'd2, 1'b0, 5'd2, 5'd0, 5'd5, 32'h8, 1'b1, 2'b10, 1'b0, 1'b0);

        send(32'hFE63_8FA3, 32'h0000_0104);
        check_dec("sb", 32'h104, 7'h23, 3'd0, 1'b0, 5'd7, 5'd6, 5'd0, 32'hFFFF_FFFF, 1'b0, 2'b00, 1'b0, 1'b0);
        check("sb64.imm", o64_imm, 64'hFFFF_FFFF_FFFF_FFFF);

        send(32'hFE00_0EE3, 32'h0000_0108);
        check_dec("beq", 32'h108, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0, 2'b00, 1'b0, 1'b0);

        send(32'h0010_00EF, 32'h0000_010C);
        check_dec("jal", 32'h10C, 7'h6F, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'h800, 1'b1, 2'b00, 1'b0, 1'b0);

        send(32'h4020_81B3, 32'h0000_0110);
        check_dec("sub", 32'h110, 7'h33, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0);

        send(32'h1234_5537, 32'h0000_0114);
        check_dec("lui", 32'h114, 7'h37, 3'd0, 1'b0, 5'd0, 5'd0, 5'd10, 32'h1234_5000, 1'b1, 2'b00, 1'b0, 1'b0);

        send(32'h0010_0073, 32'h0000_0118);
        check_dec("ebreak", 32'h118, 7'h73, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h1, 1'b0, 2'b00, 1'b0, 1'b0);

        send(32'h0000_0000, 32'h0000_011C);
        check_dec("zero", 32'h11C, 7'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1);

        send(32'h0000_3003, 32'h0000_0120);
        check_dec("ld32", 32'h120, 7'h03, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1);
        check("ld64.illegal", 64'(o64_illegal), 64'd0);
        check("ld64.size", 64'(o64_mem_size), 64'd3);

        send(32'h0081_3283, 32'h0000_0124);
        check_dec("ld32_rs", 32'h124, 7'h03, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1);
        check("ld64_rs.rd", 64'(o64_rd), 64'd5);
        check("ld64_rs.rd_we", 64'(o64_rd_we), 64'd1);

        send(32'h0000_6003, 32'h0000_0128);
        check("lwu32.illegal", 64'(out_illegal), 64'd1);
        check("lwu64.illegal", 64'(o64_illegal), 64'd0);
        check("lwu64.uns", 64'(o64_mem_unsigned), 64'd1);
        check("lwu64.size", 64'(o64_mem_size), 64'd2);

        send(32'h0000_0074, 32'h0000_012C);
        check_dec("op74", 32'h12C, 7'h74, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1);

        step();
        check("drain.valid", 64'(out_valid), 64'd0);

        // Backpressure: A and B fill the stage, C waits, then all three leave in order
        idx    = 0;
        popped = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid  = (idx < 3);
            in_instr  = 32'h0010_0093;
            in_pc     = 32'h200 + 32'(idx * 4);
            out_ready = (cyc >= 3);
            #1;
            if (cyc == 2) begin
                check("skid.in_ready_full", 64'(in_ready), 64'd0);
                check("skid.c_held", 64'(idx), 64'd2);
                check("skid.hold_pc", 64'(out_pc), 64'h200);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream.extra", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("stream.order", 64'(out_pc), 64'(exp_q.pop_front()));
                    popped++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_pc);
                idx++;
            end
            step();
        end
        in_valid = 1'b0;
        check("stream.count", 64'(popped), 64'd3);
        check("stream.idle", 64'(out_valid), 64'd0);

        // Flush while full, with a beat offered in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h300;
        step();
        in_pc = 32'h304;
        step();
        check("flush.two_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        in_pc = 32'h308;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush.valid", 64'(out_valid), 64'd0);
        check("flush.in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        check("flush.no_ghost", 64'(out_valid), 64'd0);

        // Flush in ONE drops a beat accepted in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h400;
        step();
        flush = 1'b1;
        in_pc = 32'h404;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush1.valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        step();
        check("flush1.no_ghost", 64'(out_valid), 64'd0);

        // Reset with two beats held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h500;
        step();
        in_pc = 32'h504;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        check("rst2.valid", 64'(out_valid), 64'd0);
        check("rst2.in_ready", 64'(in_ready), 64'd0);
        check("rst2.pc", 64'(out_pc), 64'd0);
        rst = 1'b0;
        #1;
        check("rst2.in_ready_after", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        check("rst2.no_ghost", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction-decode pipeline stage.
- Sits between fetch and register-read/execute.
- Decodes all base-ISA formats (R/I/S/B/U/J) with XLEN-parametrised immediates, memory access size/signedness, and illegal-instruction detection.
- Valid/ready handshake with a 2-entry skid buffer; synchronous flush for branch redirect.

Parameters:
- XLEN, 32, datapath width (32 or 64): immediate sign-extension width and LD/SD/LWU legality.
- SKID_EN, 1, 1 = two-entry skid buffer (in_ready registered); 0 = single register (in_ready = !out_valid || out_ready).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch beat valid
- in_ready  out  1  stage can accept a beat
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- flush  in  1  discard all held beats
- out_valid  out  1  decoded beat valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  passed-through PC
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]; 0 for U/J
- out_funct7_b5  out  1  instr[30] for OP and shift-immediate; else 0
- out_rs1, out_rs2, out_rd  out  5 each  register indices; 0 when unused by the format
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type
- out_rd_we  out  1  rd written and rd != 0
- out_mem_size  out  2  00 byte, 01 half, 10 word, 11 double
- out_mem_unsigned  out  1  LBU/LHU/LWU
- out_illegal  out  1  illegal encoding

Behaviour:
- Decode is combinational on in_instr. A beat transfers when in_valid && in_ready. The decoded result is registered: 1-cycle latency to out_valid.
- Formats:
  - I (OP-IMM, LOAD, JALR, SYSTEM): imm = sext(instr[31:20]).
  - S (STORE): imm = sext({[31:25],[11:7]}).
  - B (BRANCH): imm = sext({[31],[7],[30:25],[11:8],0}).
  - U (LUI, AUIPC): imm = sext({[31:12],12'b0}).
  - J (JAL): imm = sext({[31],[19:12],[20],[30:21],0}).
  - MISC-MEM (FENCE): legal no-op; all fields 0.
- Sign extension is from the top immediate bit to XLEN.
- Memory size/signedness:
  - LOAD funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU, 110 WU, 011 D.
  - STORE funct3: 000–011 → size = funct3[1:0].
  - Size and unsigned are 0 for non-memory instructions.
- Illegal conditions:
  - instr[1:0] != 11, or opcode outside the set above.
  - JALR funct3 != 0; BRANCH funct3 010/011.
  - LOAD funct3 111; STORE funct3 1xx.
  - When XLEN == 32: LOAD 011/110 and STORE 011.
  - SYSTEM other than exact ECALL 0x00000073 / EBREAK 0x00100073.
  - An illegal beat is still passed downstream with out_illegal = 1, out_opcode/out_pc kept, and every other field 0 (rd_we = 0).
- Skid FSM (SKID_EN = 1):
  - States: EMPTY, ONE (output reg valid), TWO (output + skid valid).
  - in_ready = !rst && state != TWO.
  - EMPTY → ONE on accept.
  - ONE: accept && !drain → TWO; drain && !accept → EMPTY; accept && drain → ONE, new beat loaded into output reg.
  - TWO: drain → ONE, skid moves into output reg. No accept is possible in TWO.
  - Here "drain" = out_valid && out_ready.
- Order is strictly preserved. Output fields are held stable while out_valid && !out_ready.
- flush: next state is EMPTY and out_valid = 0. A beat accepted in the same cycle is dropped. flush has priority over drain and accept.
- Reset: state EMPTY; out_valid = 0; all out_* fields 0; in_ready = 0 while rst is high and 1 on the first cycle after.
- rst high mid-stream discards held beats identically to flush.

Decomposition:
- Package decode_pkg:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM);
  - mem_size_e enum;
  - imm_fmt_e enum (R, I, S, B, U, J);
  - packed struct decoded_t holding all out_* fields except valid.
- Sub-module decode_comb: purely combinational instr → decoded_t, parametrised by XLEN.
- decode_stage instantiates it once and owns the FSM, output register and skid register.

Test Plan:
- LW x5,8(x2) = 0x00812283, out_ready = 1 → next cycle out_valid = 1, rd = 5, rs1 = 2, rs2 = 0, imm = 0x00000008, size = 10, unsigned = 0, rd_we = 1.
- SB x6,-1(x7) = 0xFE638FA3 → imm = 0xFFFFFFFF, rs1 = 7, rs2 = 6, rd = 0, size = 00, rd_we = 0; with XLEN = 64 imm = 0xFFFFFFFFFFFFFFFF.
- BEQ x0,x0,-4 = 0xFE000EE3 → imm = 0xFFFFFFFC, funct3 = 0, rd_we = 0, illegal = 0; JAL x1,+2048 = 0x001000EF → imm = 0x00000800, rd = 1.
- in_valid streams A, B, C with out_ready = 0 for 3 cycles:
  - A and B are accepted, and in_ready drops to 0 in the cycle after B is accepted.
  - C is held at the input.
  - Then out_ready = 1 → A, B, C emerge in order with no loss or duplication.
- State TWO, flush = 1 with in_valid = 1 in the same cycle → next cycle out_valid = 0, in_ready = 1, and the same-cycle beat never appears.
- 0x00000000, 0x00003003 (LD, XLEN = 32), 0x00000074 → out_illegal = 1, rs1 = rs2 = rd = 0, imm = 0, rd_we = 0; rst asserted with 2 beats held → out_valid = 0 next cycle.
